// File: rtl/alu_multicycle_if.sv
// Start/done handshake and operand/result bus between a datapath controller and alu_multicycle.
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       f;
    logic [WIDTH-1:0] oporand1;
    logic [WIDTH-1:0] oporand2;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, f, oporand1, oporand2,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, f, oporand1, oporand2,
        output result, zero, busy, done
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle logic/compare ops plus iterative shift-add multiply and
// restoring unsigned divide/remainder, launched by a start/done handshake.
module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    alu_multicycle_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSlt  = 4'b0101;
    localparam logic [3:0] OpSltu = 4'b0110;
    localparam logic [3:0] OpMul  = 4'b0111;
    localparam logic [3:0] OpDivu = 4'b1000;
    localparam logic [3:0] OpRemu = 4'b1001;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;     // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] b_q, b_d;     // multiplier, or divisor
    logic [WIDTH-1:0] acc_q, acc_d; // product accumulator, or partial remainder
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_legal;
    logic             iterative;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_fit;
    logic [WIDTH-1:0] fin;

    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (bus.f)
            OpAdd:   alu_res = bus.oporand1 + bus.oporand2;
            OpSub:   alu_res = bus.oporand1 - bus.oporand2;
            OpAnd:   alu_res = bus.oporand1 & bus.oporand2;
            OpOr:    alu_res = bus.oporand1 | bus.oporand2;
            OpXor:   alu_res = bus.oporand1 ^ bus.oporand2;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.oporand1) < $signed(bus.oporand2)};
            OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, bus.oporand1 < bus.oporand2};
            default: alu_legal = 1'b0;
        endcase
    end

    assign iterative = (bus.f == OpMul) || (bus.f == OpDivu) || (bus.f == OpRemu);

    assign mul_acc   = acc_q + (b_q[0] ? a_q : '0);
    assign div_shift = {acc_q, a_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    // No borrow means the divisor fits; a zero divisor always fits, giving all-ones quotient.
    assign div_fit   = ~div_trial[WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        fin      = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (iterative) begin
                        op_d    = bus.f;
                        a_d     = bus.oporand1;
                        b_d     = bus.oporand2;
                        acc_d   = '0;
                        cnt_d   = CntW'(WIDTH - 1);
                        state_d = StCalc;
                    end else begin
                        result_d = alu_res;
                        zero_d   = alu_legal && (alu_res == '0);
                        state_d  = StDone;
                    end
                end
            end
            StCalc: begin
                if (op_q == OpMul) begin
                    acc_d = mul_acc;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                end else begin
                    acc_d = div_fit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], div_fit};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    cnt_d    = cnt_q;
                    fin      = (op_q == OpMul)  ? mul_acc :
                               (op_q == OpDivu) ? a_d     : acc_d;
                    result_d = fin;
                    zero_d   = (fin == '0);
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
endmodule
